// File: rtl/video_output_aligner_if.sv
// ----------------------------------------------------------------------------
// video_output_aligner_if
//   Bundles the pixel-rate signals exchanged between the edge-detection core,
//   the output aligner and the downstream timing/pin logic.
//   The names keep the system-level I_*/O_* convention, seen from the aligner.
//
//   modport master : drives the I_* side and observes the O_* side (source/bench)
//   modport slave  : the aligner itself (consumes I_*, produces O_*)
//
//   Signals
//     I_VSYNC, I_HSYNC, I_DE    input timing, active high
//     I_PIX_DATA                raw pixel, CHANNELS*PIX_W bits, channel 0 in LSBs
//     I_EDGE, I_EDGE_VALID      edge magnitude and its qualifier
//     I_MODE                    0 PASS, 1 EDGE, 2 OVERLAY, 3 TEST
//     I_THRESH                  overlay threshold
//     O_PIX_DATA, O_VSYNC, O_HSYNC, O_DE, O_LOCKED, O_ALIGN_ERR   aligned outputs
// ----------------------------------------------------------------------------
interface video_output_aligner_if #(
    parameter int PIX_W    = 8,
    parameter int CHANNELS = 3,
    parameter int EDGE_W   = 8
);
    logic                        I_VSYNC;
    logic                        I_HSYNC;
    logic                        I_DE;
    logic [CHANNELS*PIX_W-1:0]   I_PIX_DATA;
    logic [EDGE_W-1:0]           I_EDGE;
    logic                        I_EDGE_VALID;
    logic [1:0]                  I_MODE;
    logic [EDGE_W-1:0]           I_THRESH;
    logic [CHANNELS*PIX_W-1:0]   O_PIX_DATA;
    logic                        O_VSYNC;
    logic                        O_HSYNC;
    logic                        O_DE;
    logic                        O_LOCKED;
    logic                        O_ALIGN_ERR;

    modport master (
        output I_VSYNC, I_HSYNC, I_DE, I_PIX_DATA, I_EDGE, I_EDGE_VALID, I_MODE, I_THRESH,
        input  O_PIX_DATA, O_VSYNC, O_HSYNC, O_DE, O_LOCKED, O_ALIGN_ERR
    );

    modport slave (
        input  I_VSYNC, I_HSYNC, I_DE, I_PIX_DATA, I_EDGE, I_EDGE_VALID, I_MODE, I_THRESH,
        output O_PIX_DATA, O_VSYNC, O_HSYNC, O_DE, O_LOCKED, O_ALIGN_ERR
    );
endinterface

// File: rtl/video_output_aligner.sv
// ----------------------------------------------------------------------------
// video_output_aligner
//   Pixel-clock output stage after the edge-detection core. Delays the input
//   sync/DE/pixel by LATENCY clocks so they meet the edge result, chooses the
//   output content once per frame and blanks the picture until it has seen a
//   frame start. Total latency from I_* to O_* is LATENCY+1 clocks.
//
//   Ports
//     O_PCLK   pixel clock, rising edge
//     I_RST    synchronous, active-high reset
//     bus      video_output_aligner_if.slave (all pixel-rate signals)
//
//   Parameters: PIX_W, CHANNELS, EDGE_W, LATENCY (1..64), HACT (>= 8)
// ----------------------------------------------------------------------------
module video_output_aligner #(
    parameter int PIX_W    = 8,
    parameter int CHANNELS = 3,
    parameter int EDGE_W   = 8,
    parameter int LATENCY  = 4,
    parameter int HACT     = 640
) (
    input  logic                    O_PCLK,
    input  logic                    I_RST,
    video_output_aligner_if.slave   bus
);

    localparam int DW      = CHANNELS * PIX_W;
    localparam int COL_W   = (HACT > 8) ? $clog2(HACT) : 3;
    localparam int BAR_DIV = ((HACT / 8) > 0) ? (HACT / 8) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(HACT - 1);

    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_EDGE    = 2'd1;
    localparam logic [1:0] MODE_OVERLAY = 2'd2;
    localparam logic [1:0] MODE_TEST    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Delay line, stage 0 nearest the input, stage LATENCY-1 is d_*
    logic [LATENCY-1:0] vs_q;
    logic [LATENCY-1:0] hs_q;
    logic [LATENCY-1:0] de_q;
    logic [DW-1:0]      pix_q [LATENCY];
    logic               d_vsync_prev_q;

    logic               d_vsync_s;
    logic               d_hsync_s;
    logic               d_de_s;
    logic [DW-1:0]      d_pix_s;
    logic               vs_rise_s;
    logic               lock_now_s;

    state_t             state_q;
    logic               locked_q;
    logic               align_err_q;
    logic [1:0]         active_mode_q;
    logic [1:0]         active_mode_d;

    logic [COL_W-1:0]   col_q;
    logic [COL_W-1:0]   col_d;
    logic [COL_W-1:0]   bar_full_s;
    logic [2:0]         bar_s;
    logic [PIX_W-1:0]   edge_scaled_s;

    logic               o_vsync_q;
    logic               o_hsync_q;
    logic               o_de_q;
    logic               o_de_d;
    logic [DW-1:0]      o_pix_q;
    logic [DW-1:0]      o_pix_d;

    assign d_vsync_s = vs_q[LATENCY-1];
    assign d_hsync_s = hs_q[LATENCY-1];
    assign d_de_s    = de_q[LATENCY-1];
    assign d_pix_s   = pix_q[LATENCY-1];
    assign vs_rise_s = d_vsync_s & ~d_vsync_prev_q;

    // The lock edge itself already counts as locked so O_DE/O_LOCKED line up with O_VSYNC.
    assign lock_now_s = (state_q == ST_LOCKED) | ((state_q == ST_WAIT) & vs_rise_s);

    // Edge magnitude mapped onto one colour channel's width.
    generate
        if (EDGE_W >= PIX_W) begin : g_edge_trunc
            assign edge_scaled_s = bus.I_EDGE[EDGE_W-1 -: PIX_W];
        end else begin : g_edge_pad
            assign edge_scaled_s = {bus.I_EDGE, {(PIX_W-EDGE_W){1'b0}}};
        end
    endgenerate

    // Shift sync/DE/pixel through the LATENCY-stage alignment pipeline.
    always_ff @(posedge O_PCLK) begin
        if (I_RST) begin
            vs_q           <= '0;
            hs_q           <= '0;
            de_q           <= '0;
            d_vsync_prev_q <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                pix_q[i] <= '0;
            end
        end else begin
            vs_q[0]        <= bus.I_VSYNC;
            hs_q[0]        <= bus.I_HSYNC;
            de_q[0]        <= bus.I_DE;
            pix_q[0]       <= bus.I_PIX_DATA;
            for (int i = 1; i < LATENCY; i++) begin
                vs_q[i]  <= vs_q[i-1];
                hs_q[i]  <= hs_q[i-1];
                de_q[i]  <= de_q[i-1];
                pix_q[i] <= pix_q[i-1];
            end
            d_vsync_prev_q <= d_vsync_s;
        end
    end

    // Lock FSM with registered O_LOCKED, sticky alignment error and per-frame mode latch.
    always_ff @(posedge O_PCLK) begin
        if (I_RST) begin
            state_q       <= ST_IDLE;
            locked_q      <= 1'b0;
            align_err_q   <= 1'b0;
            active_mode_q <= MODE_PASS;
        end else begin
            active_mode_q <= active_mode_d;
            case (state_q)
                ST_IDLE: begin
                    state_q  <= ST_WAIT;
                    locked_q <= 1'b0;
                end
                ST_WAIT: begin
                    if (vs_rise_s) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        state_q  <= ST_WAIT;
                        locked_q <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    state_q  <= ST_LOCKED;
                    locked_q <= 1'b1;
                    if (bus.I_EDGE_VALID != d_de_s) begin
                        align_err_q <= 1'b1;
                    end else begin
                        align_err_q <= align_err_q;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Next mode, column and output pixel selection.
    always_comb begin
        active_mode_d = vs_rise_s ? bus.I_MODE : active_mode_q;

        if (d_de_s) begin
            col_d = (col_q == COL_MAX) ? col_q : (col_q + COL_W'(1));
        end else begin
            col_d = '0;
        end

        bar_full_s = col_q / COL_W'(BAR_DIV);
        if (bar_full_s > COL_W'(7)) begin
            bar_s = 3'd7;
        end else begin
            bar_s = bar_full_s[2:0];
        end

        o_de_d  = d_de_s & lock_now_s;
        o_pix_d = '0;
        if (o_de_d) begin
            case (active_mode_d)
                MODE_PASS: begin
                    o_pix_d = d_pix_s;
                end
                MODE_EDGE: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        o_pix_d[c*PIX_W +: PIX_W] = edge_scaled_s;
                    end
                end
                MODE_OVERLAY: begin
                    if (bus.I_EDGE >= bus.I_THRESH) begin
                        o_pix_d = '1;
                    end else begin
                        o_pix_d = d_pix_s;
                    end
                end
                MODE_TEST: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        o_pix_d[c*PIX_W +: PIX_W] = bar_s[c % 3] ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
                    end
                end
                default: begin
                    o_pix_d = '0;
                end
            endcase
        end else begin
            o_pix_d = '0;
        end
    end

    // Output register stage and column counter.
    always_ff @(posedge O_PCLK) begin
        if (I_RST) begin
            o_vsync_q <= 1'b0;
            o_hsync_q <= 1'b0;
            o_de_q    <= 1'b0;
            o_pix_q   <= '0;
            col_q     <= '0;
        end else begin
            o_vsync_q <= d_vsync_s;
            o_hsync_q <= d_hsync_s;
            o_de_q    <= o_de_d;
            o_pix_q   <= o_pix_d;
            col_q     <= col_d;
        end
    end

    assign bus.O_VSYNC     = o_vsync_q;
    assign bus.O_HSYNC     = o_hsync_q;
    assign bus.O_DE        = o_de_q;
    assign bus.O_PIX_DATA  = o_pix_q;
    assign bus.O_LOCKED    = locked_q;
    assign bus.O_ALIGN_ERR = align_err_q;

endmodule

// File: tb/tb_video_output_aligner.sv
// ----------------------------------------------------------------------------
// tb_video_output_aligner
//   Directed bench for video_output_aligner with LATENCY=4, HACT=640, 3x8-bit
//   pixels. Inputs change 1 time unit after a rising edge ("slot" k), so a
//   value set in slot k appears on the outputs in slot k+5. I_EDGE_VALID is
//   generated here as I_DE delayed by four slots, with an optional one-slot
//   corruption.
// ----------------------------------------------------------------------------
module tb_video_output_aligner;

    localparam int PIX_W    = 8;
    localparam int CHANNELS = 3;
    localparam int EDGE_W   = 8;
    localparam int LATENCY  = 4;
    localparam int HACT     = 640;

    logic pclk;
    logic rst;

    video_output_aligner_if #(.PIX_W(PIX_W), .CHANNELS(CHANNELS), .EDGE_W(EDGE_W)) bus ();

    video_output_aligner #(
        .PIX_W(PIX_W), .CHANNELS(CHANNELS), .EDGE_W(EDGE_W),
        .LATENCY(LATENCY), .HACT(HACT)
    ) dut (
        .O_PCLK(pclk),
        .I_RST (rst),
        .bus   (bus)
    );

    int         checks;
    int         errors;
    int         slot;
    logic [3:0] de_hist;
    logic       ev_corrupt;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // One clock; I_EDGE_VALID follows I_DE four slots later.
    task automatic advance();
        de_hist = {de_hist[2:0], bus.I_DE};
        @(posedge pclk);
        #1;
        slot++;
        bus.I_EDGE_VALID = de_hist[3] ^ ev_corrupt;
    endtask

    task automatic advance_n(input int n);
        for (int i = 0; i < n; i++) advance();
    endtask

    task automatic run_to(input int target);
        while (slot < target) advance();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // VSYNC pulse carrying the mode for the next frame, then settle.
    task automatic vsync_pulse(input logic [1:0] mode);
        bus.I_MODE  = mode;
        bus.I_VSYNC = 1'b1;
        advance_n(2);
        bus.I_VSYNC = 1'b0;
        advance_n(8);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; slot = 0;
        de_hist = 4'd0; ev_corrupt = 1'b0;
        rst = 1'b1;
        bus.I_VSYNC = 1'b0; bus.I_HSYNC = 1'b0; bus.I_DE = 1'b0;
        bus.I_PIX_DATA = 24'h000000; bus.I_EDGE = 8'h00; bus.I_EDGE_VALID = 1'b0;
        bus.I_MODE = 2'd0; bus.I_THRESH = 8'd64;
        advance_n(3);

        check("rst_pix",    32'(bus.O_PIX_DATA), 32'h0);
        check("rst_de",     32'(bus.O_DE),       32'h0);
        check("rst_locked", 32'(bus.O_LOCKED),   32'h0);
        check("rst_vsync",  32'(bus.O_VSYNC),    32'h0);
        check("rst_aerr",   32'(bus.O_ALIGN_ERR),32'h0);

        rst = 1'b0;
        slot = 0;

        // 1: DE/HSYNC pulse before any frame start
        run_to(10);
        bus.I_HSYNC = 1'b1; bus.I_DE = 1'b1; bus.I_PIX_DATA = 24'hABCDEF;
        advance();
        bus.I_HSYNC = 1'b0; bus.I_DE = 1'b0;
        run_to(14);
        check("t1_hs_early", 32'(bus.O_HSYNC), 32'h0);
        advance();
        check("t1_hs_at15",  32'(bus.O_HSYNC),    32'h1);
        check("t1_de_gated", 32'(bus.O_DE),       32'h0);
        check("t1_pix_gated",32'(bus.O_PIX_DATA), 32'h0);
        check("t1_unlocked", 32'(bus.O_LOCKED),   32'h0);
        advance();
        check("t1_hs_after", 32'(bus.O_HSYNC), 32'h0);

        // 2: lock on the first frame start, then a single DE in PASS mode
        run_to(20);
        bus.I_MODE = 2'd0; bus.I_VSYNC = 1'b1;
        advance_n(3);
        bus.I_VSYNC = 1'b0;
        run_to(24);
        check("t2_vs_24",   32'(bus.O_VSYNC),  32'h0);
        check("t2_lock_24", 32'(bus.O_LOCKED), 32'h0);
        advance();
        check("t2_vs_25",   32'(bus.O_VSYNC),  32'h1);
        check("t2_lock_25", 32'(bus.O_LOCKED), 32'h1);
        run_to(40);
        bus.I_DE = 1'b1; bus.I_PIX_DATA = 24'hABCDEF;
        advance();
        bus.I_DE = 1'b0;
        run_to(44);
        check("t2_de_44", 32'(bus.O_DE), 32'h0);
        advance();
        check("t2_de_45",  32'(bus.O_DE),       32'h1);
        check("t2_pix_45", 32'(bus.O_PIX_DATA), 32'hABCDEF);
        advance();
        check("t2_de_46",  32'(bus.O_DE),       32'h0);
        check("t2_pix_46", 32'(bus.O_PIX_DATA), 32'h0);
        advance_n(4);

        // 3: EDGE mode replicates the magnitude; blanking forces zero
        vsync_pulse(2'd1);
        bus.I_DE = 1'b1; bus.I_PIX_DATA = 24'h111111; bus.I_EDGE = 8'hA5;
        advance_n(5);
        check("t3_edge", 32'(bus.O_PIX_DATA), 32'hA5A5A5);
        bus.I_DE = 1'b0;
        advance_n(5);
        check("t3_blank_de",  32'(bus.O_DE),       32'h0);
        check("t3_blank_pix", 32'(bus.O_PIX_DATA), 32'h0);
        advance_n(2);

        // 4: OVERLAY threshold boundary
        vsync_pulse(2'd2);
        bus.I_THRESH = 8'd64; bus.I_DE = 1'b1; bus.I_PIX_DATA = 24'h123456; bus.I_EDGE = 8'd63;
        advance_n(5);
        check("t4_below", 32'(bus.O_PIX_DATA), 32'h123456);
        bus.I_EDGE = 8'd64;
        advance();
        check("t4_equal", 32'(bus.O_PIX_DATA), 32'hFFFFFF);
        bus.I_EDGE = 8'd10;
        advance();
        check("t4_back",  32'(bus.O_PIX_DATA), 32'h123456);
        bus.I_DE = 1'b0;
        advance_n(8);

        // 5: TEST colour bars across one long line
        vsync_pulse(2'd3);
        bus.I_DE = 1'b1; bus.I_PIX_DATA = 24'h555555;
        advance_n(5);
        check("t5_col0",   32'(bus.O_PIX_DATA), 32'h000000);
        advance_n(79);
        check("t5_col79",  32'(bus.O_PIX_DATA), 32'h000000);
        advance();
        check("t5_col80",  32'(bus.O_PIX_DATA), 32'h0000FF);
        advance_n(80);
        check("t5_col160", 32'(bus.O_PIX_DATA), 32'h00FF00);
        advance_n(479);
        check("t5_col639", 32'(bus.O_PIX_DATA), 32'hFFFFFF);
        advance_n(61);
        check("t5_sat",    32'(bus.O_PIX_DATA), 32'hFFFFFF);
        bus.I_DE = 1'b0;
        advance_n(6);
        bus.I_DE = 1'b1;
        advance_n(5);
        check("t5_restart", 32'(bus.O_PIX_DATA), 32'h000000);
        advance_n(80);
        check("t5_restart80", 32'(bus.O_PIX_DATA), 32'h0000FF);
        bus.I_DE = 1'b0;
        advance_n(8);

        // 6: mid-frame mode change is deferred to the next frame
        vsync_pulse(2'd0);
        bus.I_DE = 1'b1; bus.I_PIX_DATA = 24'h0F0F0F; bus.I_EDGE = 8'h3C;
        advance_n(5);
        check("t6_pass", 32'(bus.O_PIX_DATA), 32'h0F0F0F);
        bus.I_MODE = 2'd1;
        advance_n(3);
        check("t6_still_pass", 32'(bus.O_PIX_DATA), 32'h0F0F0F);
        bus.I_DE = 1'b0;
        advance_n(6);
        vsync_pulse(2'd1);
        bus.I_DE = 1'b1;
        advance_n(5);
        check("t6_edge", 32'(bus.O_PIX_DATA), 32'h3C3C3C);
        check("t6_aerr_clean", 32'(bus.O_ALIGN_ERR), 32'h0);

        // Alignment error: one mismatching I_EDGE_VALID slot
        ev_corrupt = 1'b1;
        advance();
        ev_corrupt = 1'b0;
        check("t6_aerr_pre", 32'(bus.O_ALIGN_ERR), 32'h0);
        advance();
        check("t6_aerr_set", 32'(bus.O_ALIGN_ERR), 32'h1);
        bus.I_DE = 1'b0;
        advance_n(10);
        check("t6_aerr_sticky", 32'(bus.O_ALIGN_ERR), 32'h1);

        // Reset mid-frame, then relock
        bus.I_DE = 1'b1;
        advance_n(5);
        check("t7_active", 32'(bus.O_DE), 32'h1);
        rst = 1'b1;
        advance();
        check("t7_rst_de",   32'(bus.O_DE),        32'h0);
        check("t7_rst_pix",  32'(bus.O_PIX_DATA),  32'h0);
        check("t7_rst_lock", 32'(bus.O_LOCKED),    32'h0);
        check("t7_rst_aerr", 32'(bus.O_ALIGN_ERR), 32'h0);
        rst = 1'b0;
        bus.I_DE = 1'b0;
        advance_n(8);
        check("t7_unlocked", 32'(bus.O_LOCKED), 32'h0);
        bus.I_MODE = 2'd0; bus.I_VSYNC = 1'b1;
        advance_n(4);
        check("t7_relock_early", 32'(bus.O_LOCKED), 32'h0);
        advance();
        check("t7_relock", 32'(bus.O_LOCKED), 32'h1);
        bus.I_VSYNC = 1'b0;
        advance_n(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
